// File: rtl/led_scan_scheduler_pkg.sv
`default_nettype none
// ==========================================================================
// Package : led_pkg
// Desc    : Shared state encoding and sizing helpers for the LED scan path.
// Rev     : 1.0
// ==========================================================================
package led_pkg;

  localparam int c_ST_W = 7;

  // One-hot so every state decode is a single flop bit.
  typedef enum logic [c_ST_W-1:0] {
    S_IDLE    = 7'b0000001,
    S_SHIFT   = 7'b0000010,
    S_WAIT    = 7'b0000100,
    S_BLANK   = 7'b0001000,
    S_LATCH   = 7'b0010000,
    S_UNLATCH = 7'b0100000,
    S_UNBLANK = 7'b1000000
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bits_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic int on_time(input int plane, input int base_on);
    return base_on << plane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_scheduler_on_timer.sv
`default_nettype none
// ==========================================================================
// Module : led_on_timer
// Desc   : Display-time down counter; expire marks the final lit cycle.
// Rev    : 1.0
// ==========================================================================
module led_on_timer #(
  parameter int WIDTH = 10
) (
  input  logic             pll_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count  = r_count;
  // High in the cycle whose closing edge performs the 1->0 step.
  assign expire = (r_count == WIDTH'(1)) && !load;

endmodule
`default_nettype wire

// File: rtl/led_scan_scheduler.sv
`default_nettype none
// ==========================================================================
// Module : led_scan_scheduler
// Desc   : BCM row/plane scan sequencer driving shift, latch, blank, address.
// Rev    : 1.0
// ==========================================================================
module led_scan_scheduler
  import led_pkg::*;
#(
  parameter int COLUMNS    = 64,
  parameter int ROW_BITS   = 5,
  parameter int PLANES     = 8,
  parameter int BASE_ON    = 4,
  parameter int FRAME_BITS = 13
) (
  input  logic                           pll_clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           sclk_ena,
  output logic [clog2(COLUMNS)-1:0]      x,
  output logic [ROW_BITS-1:0]            row,
  output logic [bits_min1(PLANES)-1:0]   plane,
  output logic [ROW_BITS-1:0]            led_addr,
  output logic                           led_blank,
  output logic                           led_latch,
  output logic [FRAME_BITS-1:0]          frame,
  output logic                           busy
);

  localparam int c_X_BITS  = clog2(COLUMNS);
  localparam int c_P_BITS  = bits_min1(PLANES);
  localparam int c_ON_BITS = clog2(BASE_ON) + PLANES;
  localparam logic [c_X_BITS-1:0] c_X_LAST = c_X_BITS'(COLUMNS - 1);
  localparam logic [c_P_BITS-1:0] c_P_LAST = c_P_BITS'(PLANES - 1);

  state_t                 r_state;
  logic [c_ON_BITS-1:0]   w_on_cnt;
  logic [c_ON_BITS-1:0]   w_on_load;
  logic                   w_on_expire;
  logic                   w_load;
  logic                   w_last_plane;
  logic                   w_frame_end;

  assign w_load       = (r_state == S_UNBLANK);
  assign w_on_load    = c_ON_BITS'(on_time(int'(plane), BASE_ON));
  assign w_last_plane = (plane == c_P_LAST);
  assign w_frame_end  = w_last_plane && (&row);

  led_on_timer #(
    .WIDTH (c_ON_BITS)
  ) u_on_timer (
    .pll_clk  (pll_clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_on_load),
    .count    (w_on_cnt),
    .expire   (w_on_expire)
  );

  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      sclk_ena  <= 1'b0;
      x         <= '0;
      row       <= '0;
      plane     <= '0;
      led_addr  <= '0;
      led_blank <= 1'b1;
      led_latch <= 1'b0;
      frame     <= '0;
      swap_ack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      // Expiry blanks immediately, even while the next plane is shifting.
      if (w_on_expire) led_blank <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_on_cnt == '0) led_blank <= 1'b1;
          if (run) begin
            r_state  <= S_SHIFT;
            x        <= '0;
            sclk_ena <= 1'b1;
            busy     <= 1'b1;
            swap_ack <= swap_req;
          end
        end
        S_SHIFT: begin
          if (x == c_X_LAST) begin
            sclk_ena <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            x <= x + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_on_cnt == '0) r_state <= S_BLANK;
        end
        S_BLANK: begin
          led_blank <= 1'b1;
          led_addr  <= row;
          r_state   <= S_LATCH;
        end
        S_LATCH: begin
          led_latch <= 1'b1;
          r_state   <= S_UNLATCH;
        end
        S_UNLATCH: begin
          led_latch <= 1'b0;
          r_state   <= S_UNBLANK;
        end
        S_UNBLANK: begin
          led_blank <= 1'b0;
          plane     <= w_last_plane ? '0 : plane + 1'b1;
          if (w_last_plane) row <= row + 1'b1;
          if (w_frame_end) frame <= frame + 1'b1;
          if (w_frame_end && !run) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state  <= S_SHIFT;
            x        <= '0;
            sclk_ena <= 1'b1;
            if (w_frame_end) swap_ack <= swap_req;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_scheduler.sv
`default_nettype none
// ==========================================================================
// Module : tb_led_scan_scheduler
// Desc   : Scoreboard bench for the BCM scan sequencer (4 rows, 8 planes).
// Rev    : 1.0
// ==========================================================================
module tb_led_scan_scheduler;

  localparam int COLS = 64;
  localparam int RB   = 2;
  localparam int NP   = 8;
  localparam int BO   = 4;
  localparam int FB   = 2;
  localparam int XB   = 6;
  localparam int PB   = 3;
  localparam int FRAME_BUDGET = 20000;

  logic          pll_clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          swap_req = 1'b0;
  logic          swap_ack, sclk_ena, led_blank, led_latch, busy;
  logic [XB-1:0] x;
  logic [RB-1:0] row, led_addr;
  logic [PB-1:0] plane;
  logic [FB-1:0] frame;

  led_scan_scheduler #(
    .COLUMNS (COLS), .ROW_BITS (RB), .PLANES (NP), .BASE_ON (BO), .FRAME_BITS (FB)
  ) dut (
    .pll_clk   (pll_clk),
    .reset     (reset),
    .run       (run),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .sclk_ena  (sclk_ena),
    .x         (x),
    .row       (row),
    .plane     (plane),
    .led_addr  (led_addr),
    .led_blank (led_blank),
    .led_latch (led_latch),
    .frame     (frame),
    .busy      (busy)
  );

  always #5 pll_clk = ~pll_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] q_latch[$];
  int         q_blank[$];
  int         q_shift[$];
  int         q_swap[$];
  int         q_frame[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame: rows 0..3, planes 0..7, plane p lit for 4<<p cycles.
  task automatic push_frame();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NP; p++) begin
        q_latch.push_back({r[1:0], r[1:0], p[2:0]});
        q_blank.push_back(BO << p);
        q_shift.push_back(COLS);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sclk_ena"}, sclk_ena, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_plane"}, plane, 0);
    check({tag, "_led_addr"}, led_addr, 0);
    check({tag, "_led_blank"}, led_blank, 1);
    check({tag, "_led_latch"}, led_latch, 0);
    check({tag, "_frame"}, frame, 0);
    check({tag, "_swap_ack"}, swap_ack, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_frame(input int target);
    for (int i = 0; i < FRAME_BUDGET && frame != FB'(target); i++) @(negedge pll_clk);
    check("frame_reached", frame, target);
  endtask

  task automatic wait_row(input int target);
    for (int i = 0; i < FRAME_BUDGET && row != RB'(target); i++) @(negedge pll_clk);
    check("row_reached", row, target);
  endtask

  // Monitor: measures DUT events and pops expected values from the scoreboard.
  int         burst_len = 0;
  int         x_err = 0;
  int         latch_len = 0;
  int         blank_len = 0;
  int         swap_len = 0;
  logic [RB-1:0] prev_addr = '0;
  logic [FB-1:0] prev_frame = '0;

  always @(negedge pll_clk) begin
    if (reset) begin
      burst_len = 0; x_err = 0; latch_len = 0; blank_len = 0; swap_len = 0;
      prev_addr = led_addr; prev_frame = frame;
    end else begin
      if (sclk_ena) begin
        if (x != XB'(burst_len)) x_err++;
        burst_len++;
      end else if (burst_len != 0) begin
        if (q_shift.size() == 0) check("shift_unexpected", q_shift.size(), 1);
        else check("shift_len", burst_len, q_shift.pop_front());
        check("shift_x_seq_errors", x_err, 0);
        burst_len = 0; x_err = 0;
      end

      if (led_latch) begin
        if (latch_len == 0) begin
          if (q_latch.size() == 0) check("latch_unexpected", q_latch.size(), 1);
          else check("latch_addr_row_plane", {led_addr, row, plane}, q_latch.pop_front());
        end
        latch_len++;
      end else if (latch_len != 0) begin
        check("latch_width", latch_len, 1);
        latch_len = 0;
      end

      if (!led_blank) begin
        blank_len++;
      end else if (blank_len != 0) begin
        if (q_blank.size() == 0) check("blank_unexpected", q_blank.size(), 1);
        else check("blank_low_width", blank_len, q_blank.pop_front());
        blank_len = 0;
      end

      if (led_addr != prev_addr) check("addr_change_blanked", led_blank, 1);
      prev_addr = led_addr;

      if (swap_ack) begin
        if (swap_len == 0) begin
          if (q_swap.size() == 0) check("swap_unexpected", q_swap.size(), 1);
          else check("swap_at_frame_start", {sclk_ena, x, row, plane}, q_swap.pop_front());
        end
        swap_len++;
      end else if (swap_len != 0) begin
        check("swap_ack_width", swap_len, 1);
        swap_len = 0;
      end

      if (frame != prev_frame) begin
        if (q_frame.size() == 0) check("frame_unexpected", q_frame.size(), 1);
        else check("frame_value", frame, q_frame.pop_front());
      end
      prev_frame = frame;
    end
  end

  initial begin
    repeat (3) @(negedge pll_clk);
    check_reset("por");

    // Reset in the middle of the first shift burst.
    reset = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 200 && !(sclk_ena && x == XB'(30)); i++) @(negedge pll_clk);
    check("mid_shift_x", x, 30);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge pll_clk);
    check_reset("mid_shift");
    reset = 1'b0;
    repeat (4) @(negedge pll_clk);
    check("idle_without_run", busy, 0);

    // Start from IDLE with a swap request on the same cycle.
    run      = 1'b1;
    swap_req = 1'b1;
    q_swap.push_back({1'b1, 6'd0, 2'd0, 3'd0});
    push_frame();
    q_frame.push_back(1);
    for (int i = 0; i < 10 && !swap_ack; i++) @(negedge pll_clk);
    check("swap_from_idle", swap_ack, 1);
    swap_req = 1'b0;
    @(negedge pll_clk);
    check("busy_scanning", busy, 1);
    wait_frame(1);

    // Mid-frame swap request: honoured only at the next frame start.
    push_frame();
    q_frame.push_back(2);
    wait_row(1);
    swap_req = 1'b1;
    q_swap.push_back({1'b1, 6'd0, 2'd0, 3'd0});
    wait_frame(2);
    swap_req = 1'b0;

    push_frame();
    q_frame.push_back(3);
    wait_frame(3);

    push_frame();
    q_frame.push_back(0);
    wait_frame(0);

    // Drop run mid-frame: scan finishes the frame, then idles.
    push_frame();
    q_frame.push_back(1);
    wait_row(1);
    run = 1'b0;
    wait_frame(1);
    check("stop_busy", busy, 0);
    for (int i = 0; i < 1000 && !led_blank; i++) @(negedge pll_clk);
    check("stop_blank", led_blank, 1);
    repeat (50) @(negedge pll_clk);
    check("stay_idle_busy", busy, 0);
    check("stay_idle_sclk", sclk_ena, 0);
    check("stay_idle_latch", led_latch, 0);
    check("stay_idle_blank", led_blank, 1);

    check("left_latch", q_latch.size(), 0);
    check("left_blank", q_blank.size(), 0);
    check("left_shift", q_shift.size(), 0);
    check("left_swap", q_swap.size(), 0);
    check("left_frame", q_frame.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
